ysyx_22041207_rd_arbiter: RTL and testbench

//  Shares the single downstream AXI read channel between instruction fetch (IF) and the memory stage (ME).

---
 rtl/ysyx_22041207_rd_arbiter_pkg.sv | 32 +++
 rtl/ysyx_22041207_rd_arbiter_pick.sv | 17 +
 rtl/ysyx_22041207_rd_arbiter.sv | 140 ++++++++++++++
 tb/tb_ysyx_22041207_rd_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041207_rd_arbiter_pkg.sv
// Shared definitions for the IF/ME read arbiter: FSM encoding, owner ids and
// the grant priority function used by the picker.
package ysyx_22041207_rd_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_REQ  = 2'd1;
  localparam logic [1:0] ARB_DATA = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ARB_IDLE,
    ST_REQ  = ARB_REQ,
    ST_DATA = ARB_DATA
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_ME = 1'b1;

  // With both requesters valid, round-robin hands the bus to the one not served last.
  function automatic logic pick_id(input logic if_v, input logic me_v,
                                   input logic last, input logic rr_mode);
    logic id;
    if (if_v && me_v) begin
      id = rr_mode ? ~last : OWN_ME;
    end else if (me_v) begin
      id = OWN_ME;
    end else begin
      id = OWN_IF;
    end
    return id;
  endfunction

endpackage

// File: rtl/ysyx_22041207_rd_arbiter_pick.sv
// Combinational grant picker for the read arbiter: decides whether anyone is
// requesting and which requester id wins.
module ysyx_22041207_arb_pick
  import ysyx_22041207_rd_arbiter_pkg::*;
(
  input  logic if_v,
  input  logic me_v,
  input  logic last,
  input  logic rr_mode,
  output logic grant,
  output logic id
);

  assign grant = if_v | me_v;
  assign id    = pick_id(if_v, me_v, last, rr_mode);

endmodule

// File: rtl/ysyx_22041207_rd_arbiter.sv
// Read-channel arbiter between IF and ME in front of the AXI bridge.
// Define YSYX_22041207_ARB_RR_EN for round-robin priority; default is ME > IF.
module ysyx_22041207_rd_arbiter
  import ysyx_22041207_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_r_valid,
  output logic              if_r_ready,
  input  logic [ADDR_W-1:0] if_r_addr,
  input  logic [7:0]        if_r_size,
  output logic              if_d_valid,
  input  logic              if_d_ready,
  input  logic              me_r_valid,
  output logic              me_r_ready,
  input  logic [ADDR_W-1:0] me_r_addr,
  input  logic [7:0]        me_r_size,
  output logic              me_d_valid,
  input  logic              me_d_ready,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_busy,
  output logic              ax_r_valid,
  input  logic              ax_r_ready,
  output logic [ADDR_W-1:0] ax_r_addr,
  output logic [7:0]        ax_r_size,
  input  logic              ax_d_valid,
  output logic              ax_d_ready,
  input  logic [DATA_W-1:0] ax_d_data,
  output logic              owner
);

`ifdef YSYX_22041207_ARB_RR_EN
  localparam logic RR_MODE = 1'b1;
`else
  localparam logic RR_MODE = 1'b0;
`endif

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        size_q, size_d;
  logic              axv_q, axv_d;
  logic              if_rdy_q, if_rdy_d;
  logic              me_rdy_q, me_rdy_d;
  logic              pick_grant;
  logic              pick_who;
  logic              in_data;

  ysyx_22041207_arb_pick u_pick (
    .if_v    (if_r_valid),
    .me_v    (me_r_valid),
    .last    (owner_q),
    .rr_mode (RR_MODE),
    .grant   (pick_grant),
    .id      (pick_who)
  );

  // wr_busy only gates new grants; an accepted read always runs to completion.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    size_d   = size_q;
    axv_d    = axv_q;
    if_rdy_d = 1'b0;
    me_rdy_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_grant && !wr_busy) begin
          state_d  = ST_REQ;
          owner_d  = pick_who;
          addr_d   = (pick_who == OWN_ME) ? me_r_addr : if_r_addr;
          size_d   = (pick_who == OWN_ME) ? me_r_size : if_r_size;
          axv_d    = 1'b1;
          if_rdy_d = (pick_who == OWN_IF);
          me_rdy_d = (pick_who == OWN_ME);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ax_r_ready) begin
          axv_d   = 1'b0;
          state_d = ST_DATA;
        end else begin
          axv_d   = 1'b1;
        end
      end
      ST_DATA: begin
        if (ax_d_valid && ax_d_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
        axv_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_ME;
      addr_q   <= {ADDR_W{1'b0}};
      size_q   <= 8'd0;
      axv_q    <= 1'b0;
      if_rdy_q <= 1'b0;
      me_rdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      axv_q    <= axv_d;
      if_rdy_q <= if_rdy_d;
      me_rdy_q <= me_rdy_d;
    end
  end

  // Data phase is a pure pass-through to the owner; stray bridge data elsewhere is dropped.
  assign in_data    = (state_q == ST_DATA);
  assign if_d_valid = in_data && (owner_q == OWN_IF) && ax_d_valid;
  assign me_d_valid = in_data && (owner_q == OWN_ME) && ax_d_valid;
  assign ax_d_ready = in_data && ((owner_q == OWN_ME) ? me_d_ready : if_d_ready);
  assign rd_data    = ax_d_data;

  assign if_r_ready = if_rdy_q;
  assign me_r_ready = me_rdy_q;
  assign ax_r_valid = axv_q;
  assign ax_r_addr  = addr_q;
  assign ax_r_size  = size_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_ysyx_22041207_rd_arbiter.sv
// Directed self-checking bench for ysyx_22041207_rd_arbiter; inputs change on
// the falling edge and outputs are sampled 1 time unit later.
module tb_ysyx_22041207_rd_arbiter;

`ifdef YSYX_22041207_ARB_RR_EN
  localparam logic FIRST_ID = 1'b0;
`else
  localparam logic FIRST_ID = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_r_valid, if_r_ready, if_d_valid, if_d_ready;
  logic [63:0] if_r_addr;
  logic [7:0]  if_r_size;
  logic        me_r_valid, me_r_ready, me_d_valid, me_d_ready;
  logic [63:0] me_r_addr;
  logic [7:0]  me_r_size;
  logic [63:0] rd_data;
  logic        wr_busy;
  logic        ax_r_valid, ax_r_ready, ax_d_valid, ax_d_ready;
  logic [63:0] ax_r_addr;
  logic [7:0]  ax_r_size;
  logic [63:0] ax_d_data;
  logic        owner;
  int          tests = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  ysyx_22041207_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .if_r_valid(if_r_valid), .if_r_ready(if_r_ready), .if_r_addr(if_r_addr), .if_r_size(if_r_size),
    .if_d_valid(if_d_valid), .if_d_ready(if_d_ready),
    .me_r_valid(me_r_valid), .me_r_ready(me_r_ready), .me_r_addr(me_r_addr), .me_r_size(me_r_size),
    .me_d_valid(me_d_valid), .me_d_ready(me_d_ready),
    .rd_data(rd_data), .wr_busy(wr_busy),
    .ax_r_valid(ax_r_valid), .ax_r_ready(ax_r_ready), .ax_r_addr(ax_r_addr), .ax_r_size(ax_r_size),
    .ax_d_valid(ax_d_valid), .ax_d_ready(ax_d_ready), .ax_d_data(ax_d_data), .owner(owner)
  );

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Drives the remainder of a granted read (called on the grant-observed cycle); no checks.
  task automatic complete_txn(input logic own, input logic [63:0] data);
    if (own) me_r_valid = 1'b0; else if_r_valid = 1'b0;
    ax_r_ready = 1'b1;
    @(negedge clk);
    ax_r_ready = 1'b0; ax_d_valid = 1'b1; ax_d_data = data; if_d_ready = 1'b1; me_d_ready = 1'b1;
    @(negedge clk);
    ax_d_valid = 1'b0; if_d_ready = 1'b0; me_d_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; if_r_valid = 1'b1; if_r_addr = 64'h0000_0000_8000_0000; ax_d_valid = 1'b1;
    @(negedge clk); #1;
    tests++; if (ax_r_valid !== 1'b0) begin failed++; $display("FAIL rst_ax_r_valid got %b exp 0", ax_r_valid); end
    tests++; if ({if_r_ready, me_r_ready} !== 2'b00) begin failed++; $display("FAIL rst_r_ready got %b exp 00", {if_r_ready, me_r_ready}); end
    tests++; if (ax_r_addr !== 64'h0) begin failed++; $display("FAIL rst_addr got %h exp 0", ax_r_addr); end
    tests++; if (ax_r_size !== 8'h0) begin failed++; $display("FAIL rst_size got %h exp 0", ax_r_size); end
    tests++; if (owner !== 1'b1) begin failed++; $display("FAIL rst_owner got %b exp 1", owner); end
    tests++; if ({if_d_valid, me_d_valid, ax_d_ready} !== 3'b000) begin failed++; $display("FAIL rst_stray_data got %b exp 000", {if_d_valid, me_d_valid, ax_d_ready}); end
    rst = 1'b0; if_r_valid = 1'b0; ax_d_valid = 1'b0;
  endtask

  task automatic test_if_read();
    @(negedge clk); if_r_valid = 1'b1; if_r_addr = 64'h0000_0000_8000_0000; if_r_size = 8'd4;
    #1;
    tests++; if (ax_r_valid !== 1'b0) begin failed++; $display("FAIL if_pre_grant got %b exp 0", ax_r_valid); end
    @(negedge clk); #1;
    tests++; if ({if_r_ready, me_r_ready, ax_r_valid} !== 3'b101) begin failed++; $display("FAIL if_grant got %b exp 101", {if_r_ready, me_r_ready, ax_r_valid}); end
    tests++; if (ax_r_addr !== 64'h0000_0000_8000_0000 || ax_r_size !== 8'd4) begin failed++; $display("FAIL if_addr got %h/%0d exp 80000000/4", ax_r_addr, ax_r_size); end
    tests++; if (owner !== 1'b0) begin failed++; $display("FAIL if_owner got %b exp 0", owner); end
    if_r_valid = 1'b0; ax_r_ready = 1'b1;
    @(negedge clk); #1;
    tests++; if ({if_r_ready, ax_r_valid} !== 2'b00) begin failed++; $display("FAIL if_req_done got %b exp 00", {if_r_ready, ax_r_valid}); end
    ax_r_ready = 1'b0; ax_d_valid = 1'b1; ax_d_data = 64'h1234; if_d_ready = 1'b1;
    #1;
    tests++; if ({if_d_valid, me_d_valid, ax_d_ready} !== 3'b101) begin failed++; $display("FAIL if_data_route got %b exp 101", {if_d_valid, me_d_valid, ax_d_ready}); end
    tests++; if (rd_data !== 64'h1234) begin failed++; $display("FAIL if_rd_data got %h exp 1234", rd_data); end
    @(negedge clk); ax_d_valid = 1'b1; #1;
    tests++; if ({if_d_valid, ax_d_ready} !== 2'b00) begin failed++; $display("FAIL if_back_idle got %b exp 00", {if_d_valid, ax_d_ready}); end
    ax_d_valid = 1'b0; if_d_ready = 1'b0;
  endtask

  task automatic test_priority();
    apply_reset();
    for (int round = 0; round < 2; round++) begin
      @(negedge clk);
      if_r_valid = 1'b1; if_r_addr = 64'h0000_0000_8000_1000; if_r_size = 8'd4;
      me_r_valid = 1'b1; me_r_addr = 64'h0000_0000_8000_2000; me_r_size = 8'd8;
      @(negedge clk); #1;
      tests++; if ({owner, me_r_ready, if_r_ready} !== {FIRST_ID, FIRST_ID, ~FIRST_ID}) begin failed++; $display("FAIL prio_first r%0d got %b exp %b", round, {owner, me_r_ready, if_r_ready}, {FIRST_ID, FIRST_ID, ~FIRST_ID}); end
      tests++; if (ax_r_addr !== (FIRST_ID ? 64'h0000_0000_8000_2000 : 64'h0000_0000_8000_1000)) begin failed++; $display("FAIL prio_first_addr r%0d got %h", round, ax_r_addr); end
      complete_txn(FIRST_ID, 64'hAAAA);
      #1;
      tests++; if (ax_r_valid !== 1'b0) begin failed++; $display("FAIL prio_idle r%0d got %b exp 0", round, ax_r_valid); end
      @(negedge clk); #1;
      tests++; if ({owner, me_r_ready, if_r_ready, ax_r_valid} !== {~FIRST_ID, ~FIRST_ID, FIRST_ID, 1'b1}) begin failed++; $display("FAIL prio_second r%0d got %b exp %b", round, {owner, me_r_ready, if_r_ready, ax_r_valid}, {~FIRST_ID, ~FIRST_ID, FIRST_ID, 1'b1}); end
      complete_txn(~FIRST_ID, 64'hBBBB);
    end
  endtask

  task automatic test_wr_busy();
    @(negedge clk); wr_busy = 1'b1; me_r_valid = 1'b1; me_r_addr = 64'h0000_0000_9000_0000; me_r_size = 8'd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      tests++; if ({ax_r_valid, me_r_ready} !== 2'b00) begin failed++; $display("FAIL busy_hold c%0d got %b exp 00", i, {ax_r_valid, me_r_ready}); end
    end
    wr_busy = 1'b0;
    @(negedge clk); #1;
    tests++; if ({ax_r_valid, me_r_ready, owner} !== 3'b111) begin failed++; $display("FAIL busy_release got %b exp 111", {ax_r_valid, me_r_ready, owner}); end
    me_r_valid = 1'b0; ax_r_ready = 1'b1; wr_busy = 1'b1;
    @(negedge clk);
    ax_r_ready = 1'b0; ax_d_valid = 1'b1; ax_d_data = 64'h5555; me_d_ready = 1'b1; #1;
    tests++; if ({me_d_valid, if_d_valid, ax_d_ready} !== 3'b101) begin failed++; $display("FAIL busy_mid_read got %b exp 101", {me_d_valid, if_d_valid, ax_d_ready}); end
    @(negedge clk); ax_d_valid = 1'b0; me_d_ready = 1'b0; wr_busy = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk); if_r_valid = 1'b1; if_r_addr = 64'h0000_0000_8000_0040; if_r_size = 8'd2;
    @(negedge clk); if_r_valid = 1'b0; ax_r_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      tests++; if (ax_r_valid !== 1'b1 || ax_r_addr !== 64'h0000_0000_8000_0040 || ax_r_size !== 8'd2) begin failed++; $display("FAIL bp_req_hold c%0d got %b/%h/%0d", i, ax_r_valid, ax_r_addr, ax_r_size); end
    end
    ax_r_ready = 1'b1;
    @(negedge clk);
    ax_r_ready = 1'b0; ax_d_valid = 1'b1; ax_d_data = 64'hDEAD_BEEF; if_d_ready = 1'b0; #1;
    tests++; if ({ax_r_valid, if_d_valid, ax_d_ready} !== 3'b010) begin failed++; $display("FAIL bp_dready_c0 got %b exp 010", {ax_r_valid, if_d_valid, ax_d_ready}); end
    @(negedge clk); #1;
    tests++; if ({if_d_valid, ax_d_ready} !== 2'b10) begin failed++; $display("FAIL bp_dready_c1 got %b exp 10", {if_d_valid, ax_d_ready}); end
    if_d_ready = 1'b1; #1;
    tests++; if ({if_d_valid, ax_d_ready} !== 2'b11 || rd_data !== 64'hDEAD_BEEF) begin failed++; $display("FAIL bp_data got %b/%h exp 11/deadbeef", {if_d_valid, ax_d_ready}, rd_data); end
    @(negedge clk); #1;
    tests++; if ({if_d_valid, ax_d_ready} !== 2'b00) begin failed++; $display("FAIL bp_done got %b exp 00", {if_d_valid, ax_d_ready}); end
    ax_d_valid = 1'b0; if_d_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); if_r_valid = 1'b1; if_r_addr = 64'h0000_0000_8000_0080; if_r_size = 8'd4;
    @(negedge clk); if_r_valid = 1'b0; ax_r_ready = 1'b1;
    @(negedge clk); ax_r_ready = 1'b0; ax_d_valid = 1'b1; ax_d_data = 64'h7777; if_d_ready = 1'b0;
    #1;
    tests++; if (if_d_valid !== 1'b1) begin failed++; $display("FAIL rmid_in_data got %b exp 1", if_d_valid); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; if_d_ready = 1'b1; #1;
    tests++; if ({if_d_valid, me_d_valid, ax_d_ready, ax_r_valid, if_r_ready, me_r_ready} !== 6'b000000) begin failed++; $display("FAIL rmid_outputs got %b exp 000000", {if_d_valid, me_d_valid, ax_d_ready, ax_r_valid, if_r_ready, me_r_ready}); end
    tests++; if ({owner, ax_r_addr, ax_r_size} !== {1'b1, 64'h0, 8'h0}) begin failed++; $display("FAIL rmid_regs got %b/%h/%h exp 1/0/0", owner, ax_r_addr, ax_r_size); end
    ax_d_valid = 1'b0; if_d_ready = 1'b0;
    if_r_valid = 1'b1; if_r_addr = 64'h0000_0000_8000_00C0;
    @(negedge clk); #1;
    tests++; if ({if_r_ready, ax_r_valid, owner} !== 3'b110 || ax_r_addr !== 64'h0000_0000_8000_00C0) begin failed++; $display("FAIL rmid_fresh_grant got %b/%h", {if_r_ready, ax_r_valid, owner}, ax_r_addr); end
    if_r_valid = 1'b0; ax_r_ready = 1'b1;
    @(negedge clk); ax_r_ready = 1'b0; ax_d_valid = 1'b1; ax_d_data = 64'h9999; if_d_ready = 1'b1; #1;
    tests++; if (if_d_valid !== 1'b1 || rd_data !== 64'h9999) begin failed++; $display("FAIL rmid_fresh_data got %b/%h exp 1/9999", if_d_valid, rd_data); end
    @(negedge clk); ax_d_valid = 1'b0; if_d_ready = 1'b0; #1;
    tests++; if (ax_r_valid !== 1'b0 || if_d_valid !== 1'b0) begin failed++; $display("FAIL rmid_fresh_idle got %b%b exp 00", ax_r_valid, if_d_valid); end
  endtask

  initial begin
    rst = 1'b1; wr_busy = 1'b0;
    if_r_valid = 1'b0; if_r_addr = 64'h0; if_r_size = 8'h0; if_d_ready = 1'b0;
    me_r_valid = 1'b0; me_r_addr = 64'h0; me_r_size = 8'h0; me_d_ready = 1'b0;
    ax_r_ready = 1'b0; ax_d_valid = 1'b0; ax_d_data = 64'h0;
    test_reset();
    test_if_read();
    test_priority();
    test_wr_busy();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
